fft_stage_sequencer: RTL and testbench
======================================

// Module: fft_stage_sequencer
// PURPOSE
//  Sequences an in-place radix-2 DIT FFT over an external sample RAM and the twiddle multipliers.
//  Phases: bit-reversed load from an input stream, LOG2N butterfly stages, natural-order unload.
//  Each phase issues RAM addresses, write strobes and write-source select.
//  Drives per-butterfly twiddle codes (mag, neg) to the real- and imag-path multipliers.
// PARAMETERS
//  LOG2N   3   log2 of FFT size. Legal values are 2 and 3 only; twiddle codes cover only 0, 0.707 and 1.
// PORTS
//  i_clk           in   1      clock; all state changes on the rising edge
//  i_rst_n         in   1      asynchronous, active-low reset
//  i_start         in   1      begin a transform; sampled in IDLE only
//  i_abort         in   1      synchronous abort; forces IDLE on the next edge
//  i_in_valid      in   1      input sample present
//  o_in_ready      out  1      controller accepts an input sample (LOAD only)
//  o_out_valid     out  1      RAM output at o_ram_raddr_a is a result sample
//  i_out_ready     in   1      downstream accepts the result sample
//  o_out_idx       out  LOG2N  bin index of the current result
//  o_ram_raddr_a   out  LOG2N  read address, top/primary
//  o_ram_raddr_b   out  LOG2N  read address, bottom
//  o_ram_we        out  1      write strobe; writes both a and b in COMPUTE, only a in LOAD
//  o_ram_waddr_a   out  LOG2N  write address, top
//  o_ram_waddr_b   out  LOG2N  write address, bottom
//  o_wsel          out  1      0 = write input sample, 1 = write butterfly result
//  o_tw_re_mag     out  2      twiddle real magnitude code: 00 = 0, 01 = 0.707, 10 = 1
//  o_tw_re_neg     out  1      twiddle real sign
//  o_tw_im_mag     out  2      twiddle imag magnitude code
//  o_tw_im_neg     out  1      twiddle imag sign
//  o_busy          out  1      high in every state except IDLE
//  o_done          out  1      one-cycle pulse after the last result is accepted
// BEHAVIOUR
//  Reset: all outputs and counters are 0; state IDLE. Reset acts immediately in any state.
//  States and transitions:
//   IDLE -> LOAD on i_start.
//   LOAD: o_in_ready=1. Each cycle with i_in_valid=1 writes o_ram_we=1, o_wsel=0,
//    o_ram_waddr_a = bitrev(cnt), then cnt++. The write with cnt=N-1 goes to BF_RD with stage=0, bf=0.
//   BF_RD: 1 cycle. raddr_a=top, raddr_b=bot; twiddle codes valid. The RAM has 1-cycle read latency.
//   BF_WR: 1 cycle. o_ram_we=1, o_wsel=1, waddr = same top/bot. Addresses and twiddles are held.
//    On exit bf++. After bf=N/2-1, stage++. After the last stage, go to UN_RD with cnt=0.
//   UN_RD: raddr_a=cnt, 1 cycle -> UN_VAL.
//   UN_VAL: o_out_valid=1, o_out_idx=cnt; raddr_a is held until i_out_ready.
//    On accept, cnt++ and go to UN_RD. Accept with cnt=N-1 -> DONE.
//   DONE: o_done=1 for 1 cycle -> IDLE.
//  Address generation, per stage s and butterfly b:
//   half = 1<<s; j = b & (half-1); top = ((b>>s)<<(s+1)) | j; bot = top + half.
//   k = j << (LOG2N-1-s), scaled to N=8 as k8 = k << (3-LOG2N).
//  Twiddle table W^k8 = exp(-j*2*pi*k8/8), as (re_mag,re_neg | im_mag,im_neg):
//   k8=0: 10,0 | 00,0.   k8=1: 01,0 | 01,1.   k8=2: 00,0 | 10,1.   k8=3: 01,1 | 01,1.
//  Twiddle outputs are registered and are 0 outside BF_RD/BF_WR.
//  Compute latency is exactly LOG2N * N/2 * 2 cycles; N=8 gives 24.
//  Boundary conditions:
//   - i_start outside IDLE is ignored.
//   - i_abort has priority over every transition: next state IDLE, no o_done, o_ram_we=0 on that edge.
//   - A gap in i_in_valid holds cnt.
//   - i_out_ready low holds o_out_valid, o_out_idx and raddr_a stable.
//   - Simultaneous i_start and i_abort in IDLE: the block stays in IDLE.
// STRUCTURE
//  Package fft_pkg: state enum; TW_ZERO=2'b00, TW_HALF=2'b01, TW_ONE=2'b10; bitrev function.
//  Sub-module fft_twiddle_lut: combinational, k8[1:0] -> {re_mag, re_neg, im_mag, im_neg}.
// TESTING
//  1 Reset asserted mid-BF_WR -> all outputs 0 in the same cycle; IDLE after release; o_in_ready=0.
//  2 start, 8 samples with valid gaps at samples 3 and 6 -> waddr_a sequence 0,4,2,6,1,5,3,7, all with o_wsel=0.
//  3 Compute phase:
//    - stage0 pairs (0,1),(2,3),(4,5),(6,7), twiddle 10,0|00,0.
//    - stage2 pairs (0,4) k8=0, (1,5) 01,0|01,1, (2,6) 00,0|10,1, (3,7) 01,1|01,1.
//    - 24 cycles total; o_ram_we asserted on alternate cycles.
//  4 Unload with i_out_ready low for 3 cycles at idx 2 -> valid, idx and raddr held;
//    idx sequence 0..7; o_done pulses once, 1 cycle after the idx-7 accept.
//  5 i_abort during stage1 bf2 -> IDLE next cycle, o_busy=0, no o_done.
//    i_start pulsed mid-LOAD -> no effect on cnt.
//  6 LOG2N=2 -> load order 0,2,1,3.
//    Stage1 pair (1,3) uses k8=2: 00,0|10,1. Compute takes 8 cycles.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state codes, twiddle magnitude codes and bit reversal for the FFT sequencer
package fft_pkg;

    typedef logic [2:0] fft_state_t;

    localparam fft_state_t ST_IDLE   = 3'd0;
    localparam fft_state_t ST_LOAD   = 3'd1;
    localparam fft_state_t ST_BF_RD  = 3'd2;
    localparam fft_state_t ST_BF_WR  = 3'd3;
    localparam fft_state_t ST_UN_RD  = 3'd4;
    localparam fft_state_t ST_UN_VAL = 3'd5;
    localparam fft_state_t ST_DONE   = 3'd6;

    localparam logic [1:0] TW_ZERO = 2'b00;
    localparam logic [1:0] TW_HALF = 2'b01;
    localparam logic [1:0] TW_ONE  = 2'b10;

    // Reverses the low w bits of v; bits at and above w come back as 0.
    function automatic logic [7:0] bitrev(input logic [7:0] v, input int w);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_twiddle_lut.sv
// rtl/fft_twiddle_lut.sv - W^k8 = exp(-j*2*pi*k8/8) as magnitude/sign codes for k8 in 0..3
module fft_twiddle_lut
    import fft_pkg::*;
(
    input  logic [1:0] k8_i,
    output logic [1:0] re_mag_o,
    output logic       re_neg_o,
    output logic [1:0] im_mag_o,
    output logic       im_neg_o
);

    always_comb begin
        re_mag_o = TW_ZERO;
        re_neg_o = 1'b0;
        im_mag_o = TW_ZERO;
        im_neg_o = 1'b0;
        case (k8_i)
            2'd0: begin
                re_mag_o = TW_ONE;
            end
            2'd1: begin
                re_mag_o = TW_HALF;
                im_mag_o = TW_HALF;
                im_neg_o = 1'b1;
            end
            2'd2: begin
                im_mag_o = TW_ONE;
                im_neg_o = 1'b1;
            end
            default: begin
                re_mag_o = TW_HALF;
                re_neg_o = 1'b1;
                im_mag_o = TW_HALF;
                im_neg_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - in-place radix-2 DIT FFT controller: bit-reversed load, butterfly stages, unload
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [LOG2N-1:0] o_out_idx,
    output logic [LOG2N-1:0] o_ram_raddr_a,
    output logic [LOG2N-1:0] o_ram_raddr_b,
    output logic             o_ram_we,
    output logic [LOG2N-1:0] o_ram_waddr_a,
    output logic [LOG2N-1:0] o_ram_waddr_b,
    output logic             o_wsel,
    output logic [1:0]       o_tw_re_mag,
    output logic             o_tw_re_neg,
    output logic [1:0]       o_tw_im_mag,
    output logic             o_tw_im_neg,
    output logic             o_busy,
    output logic             o_done
);

    localparam int AW = LOG2N;
    localparam int N  = 1 << LOG2N;

    fft_state_t    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] bf_q, bf_d;
    logic [1:0]    stage_q, stage_d;
    logic [5:0]    tw_q, tw_d;

    logic [1:0]    k8_d;
    logic [1:0]    lut_re_mag, lut_im_mag;
    logic          lut_re_neg, lut_im_neg;
    logic [AW-1:0] top_addr, bot_addr;

    function automatic logic [AW-1:0] bf_top(input logic [1:0] s, input logic [AW-1:0] b);
        logic [AW-1:0] half_m1;
        half_m1 = (AW'(1) << s) - AW'(1);
        return ((b >> s) << (s + 2'd1)) | (b & half_m1);
    endfunction

    // j << (LOG2N-1-s) << (3-LOG2N) collapses to j << (2-s) for either legal LOG2N.
    function automatic logic [1:0] bf_k8(input logic [1:0] s, input logic [AW-1:0] b);
        logic [AW-1:0] half_m1;
        logic [2:0]    j3;
        half_m1 = (AW'(1) << s) - AW'(1);
        j3      = 3'(b & half_m1);
        return 2'(j3 << (2'd2 - s));
    endfunction

    assign top_addr = bf_top(stage_q, bf_q);
    assign bot_addr = top_addr + (AW'(1) << stage_q);
    assign k8_d     = bf_k8(stage_d, bf_d);

    fft_twiddle_lut u_twiddle_lut (
        .k8_i     (k8_d),
        .re_mag_o (lut_re_mag),
        .re_neg_o (lut_re_neg),
        .im_mag_o (lut_im_mag),
        .im_neg_o (lut_im_neg)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bf_d    = bf_q;
        stage_d = stage_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (i_in_valid) begin
                    if (cnt_q == AW'(N-1)) begin
                        state_d = ST_BF_RD;
                        cnt_d   = '0;
                        stage_d = '0;
                        bf_d    = '0;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            ST_BF_RD: state_d = ST_BF_WR;
            ST_BF_WR: begin
                state_d = ST_BF_RD;
                if (bf_q == AW'(N/2-1)) begin
                    bf_d = '0;
                    if (stage_q == 2'(LOG2N-1)) begin
                        state_d = ST_UN_RD;
                        stage_d = '0;
                        cnt_d   = '0;
                    end else begin
                        stage_d = stage_q + 2'd1;
                    end
                end else begin
                    bf_d = bf_q + AW'(1);
                end
            end
            ST_UN_RD: state_d = ST_UN_VAL;
            ST_UN_VAL: begin
                if (i_out_ready) begin
                    if (cnt_q == AW'(N-1)) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_UN_RD;
                        cnt_d   = cnt_q + AW'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (i_abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            bf_d    = '0;
            stage_d = '0;
        end
    end

    // Twiddles are loaded on the edge entering BF_RD so they are already valid there.
    always_comb begin
        tw_d = '0;
        if (state_d == ST_BF_RD || state_d == ST_BF_WR) begin
            tw_d = {lut_re_mag, lut_re_neg, lut_im_mag, lut_im_neg};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bf_q    <= '0;
            stage_q <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bf_q    <= bf_d;
            stage_q <= stage_d;
            tw_q    <= tw_d;
        end
    end

    always_comb begin
        o_in_ready    = 1'b0;
        o_out_valid   = 1'b0;
        o_out_idx     = '0;
        o_ram_raddr_a = '0;
        o_ram_raddr_b = '0;
        o_ram_we      = 1'b0;
        o_ram_waddr_a = '0;
        o_ram_waddr_b = '0;
        o_wsel        = 1'b0;
        o_done        = 1'b0;
        case (state_q)
            ST_LOAD: begin
                o_in_ready    = 1'b1;
                o_ram_we      = i_in_valid & ~i_abort;
                o_ram_waddr_a = AW'(bitrev(8'(cnt_q), LOG2N));
            end
            ST_BF_RD: begin
                o_ram_raddr_a = top_addr;
                o_ram_raddr_b = bot_addr;
            end
            ST_BF_WR: begin
                o_ram_raddr_a = top_addr;
                o_ram_raddr_b = bot_addr;
                o_ram_we      = ~i_abort;
                o_wsel        = 1'b1;
                o_ram_waddr_a = top_addr;
                o_ram_waddr_b = bot_addr;
            end
            ST_UN_RD: begin
                o_ram_raddr_a = cnt_q;
            end
            ST_UN_VAL: begin
                o_ram_raddr_a = cnt_q;
                o_out_valid   = 1'b1;
                o_out_idx     = cnt_q;
            end
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_tw_re_mag = tw_q[5:4];
    assign o_tw_re_neg = tw_q[3];
    assign o_tw_im_mag = tw_q[2:1];
    assign o_tw_im_neg = tw_q[0];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - directed table-driven bench for N=8 and N=4 sequencers
module tb_fft_stage_sequencer;

    typedef struct {
        logic [2:0] top;
        logic [2:0] bot;
        logic [5:0] tw;
    } bf_vec_t;

    localparam logic [5:0] T0 = 6'b10_0_00_0;
    localparam logic [5:0] T1 = 6'b01_0_01_1;
    localparam logic [5:0] T2 = 6'b00_0_10_1;
    localparam logic [5:0] T3 = 6'b01_1_01_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start8, start4, abort, in_valid, out_ready;

    logic       in_ready8, out_valid8, we8, wsel8, busy8, done8, re_neg8, im_neg8;
    logic [2:0] out_idx8, raddr_a8, raddr_b8, waddr_a8, waddr_b8;
    logic [1:0] re_mag8, im_mag8;

    logic       in_ready4, out_valid4, we4, wsel4, busy4, done4, re_neg4, im_neg4;
    logic [1:0] out_idx4, raddr_a4, raddr_b4, waddr_a4, waddr_b4;
    logic [1:0] re_mag4, im_mag4;

    fft_stage_sequencer #(.LOG2N(3)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_abort(abort),
        .i_in_valid(in_valid), .o_in_ready(in_ready8), .o_out_valid(out_valid8),
        .i_out_ready(out_ready), .o_out_idx(out_idx8),
        .o_ram_raddr_a(raddr_a8), .o_ram_raddr_b(raddr_b8), .o_ram_we(we8),
        .o_ram_waddr_a(waddr_a8), .o_ram_waddr_b(waddr_b8), .o_wsel(wsel8),
        .o_tw_re_mag(re_mag8), .o_tw_re_neg(re_neg8), .o_tw_im_mag(im_mag8),
        .o_tw_im_neg(im_neg8), .o_busy(busy8), .o_done(done8)
    );

    fft_stage_sequencer #(.LOG2N(2)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_abort(abort),
        .i_in_valid(in_valid), .o_in_ready(in_ready4), .o_out_valid(out_valid4),
        .i_out_ready(out_ready), .o_out_idx(out_idx4),
        .o_ram_raddr_a(raddr_a4), .o_ram_raddr_b(raddr_b4), .o_ram_we(we4),
        .o_ram_waddr_a(waddr_a4), .o_ram_waddr_b(waddr_b4), .o_wsel(wsel4),
        .o_tw_re_mag(re_mag4), .o_tw_re_neg(re_neg4), .o_tw_im_mag(im_mag4),
        .o_tw_im_neg(im_neg4), .o_busy(busy4), .o_done(done4)
    );

    bit         use4;
    logic       s_in_ready, s_out_valid, s_we, s_wsel, s_busy, s_done;
    logic [2:0] s_out_idx, s_raddr_a, s_raddr_b, s_waddr_a, s_waddr_b;
    logic [5:0] s_tw;

    always_comb begin
        s_in_ready  = use4 ? in_ready4  : in_ready8;
        s_out_valid = use4 ? out_valid4 : out_valid8;
        s_we        = use4 ? we4        : we8;
        s_wsel      = use4 ? wsel4      : wsel8;
        s_busy      = use4 ? busy4      : busy8;
        s_done      = use4 ? done4      : done8;
        s_out_idx   = use4 ? {1'b0, out_idx4} : out_idx8;
        s_raddr_a   = use4 ? {1'b0, raddr_a4} : raddr_a8;
        s_raddr_b   = use4 ? {1'b0, raddr_b4} : raddr_b8;
        s_waddr_a   = use4 ? {1'b0, waddr_a4} : waddr_a8;
        s_waddr_b   = use4 ? {1'b0, waddr_b4} : waddr_b8;
        s_tw        = use4 ? {re_mag4, re_neg4, im_mag4, im_neg4}
                           : {re_mag8, re_neg8, im_mag8, im_neg8};
    end

    bf_vec_t    bf8 [12];
    bf_vec_t    bf4 [4];
    logic [2:0] ld8 [8];
    logic [2:0] ld4 [4];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic do_load(input int n, input bit gaps, input bit start_pulse);
        int i;
        bit gap;
        i = 0;
        for (int c = 0; c < n + (gaps ? 2 : 0); c++) begin
            gap      = gaps && (c == 3 || c == 7);
            in_valid = !gap;
            start8   = start_pulse && gap;
            #1;
            chk("ld_ready", s_in_ready, 1);
            chk("ld_we", s_we, !gap);
            if (!gap) begin
                chk("ld_waddr", s_waddr_a, use4 ? ld4[i] : ld8[i]);
                chk("ld_wsel", s_wsel, 0);
                i++;
            end
            cyc;
        end
        in_valid = 1'b0;
        start8   = 1'b0;
    endtask

    task automatic do_compute(input int nbf);
        bf_vec_t v;
        for (int b = 0; b < nbf; b++) begin
            v = use4 ? bf4[b] : bf8[b];
            #1;
            chk("rd_we", s_we, 0);
            chk("rd_raddr_a", s_raddr_a, v.top);
            chk("rd_raddr_b", s_raddr_b, v.bot);
            chk("rd_tw", s_tw, v.tw);
            cyc;
            chk("wr_we", s_we, 1);
            chk("wr_wsel", s_wsel, 1);
            chk("wr_waddr_a", s_waddr_a, v.top);
            chk("wr_waddr_b", s_waddr_b, v.bot);
            chk("wr_tw", s_tw, v.tw);
            cyc;
        end
    endtask

    task automatic do_unload(input int n, input int stall_idx);
        for (int k = 0; k < n; k++) begin
            #1;
            chk("un_rd_valid", s_out_valid, 0);
            chk("un_rd_raddr", s_raddr_a, k);
            chk("un_rd_we", s_we, 0);
            cyc;
            if (k == stall_idx) begin
                out_ready = 1'b0;
                for (int w = 0; w < 3; w++) begin
                    #1;
                    chk("stall_valid", s_out_valid, 1);
                    chk("stall_idx", s_out_idx, k);
                    chk("stall_raddr", s_raddr_a, k);
                    cyc;
                end
                out_ready = 1'b1;
            end
            #1;
            chk("un_valid", s_out_valid, 1);
            chk("un_idx", s_out_idx, k);
            chk("un_raddr", s_raddr_a, k);
            chk("un_no_done", s_done, 0);
            cyc;
        end
        #1;
        chk("done_pulse", s_done, 1);
        chk("done_busy", s_busy, 1);
        cyc;
        chk("done_clear", s_done, 0);
        chk("idle_busy", s_busy, 0);
    endtask

    initial begin
        bf8[0]  = '{3'd0, 3'd1, T0};  bf8[1]  = '{3'd2, 3'd3, T0};
        bf8[2]  = '{3'd4, 3'd5, T0};  bf8[3]  = '{3'd6, 3'd7, T0};
        bf8[4]  = '{3'd0, 3'd2, T0};  bf8[5]  = '{3'd1, 3'd3, T2};
        bf8[6]  = '{3'd4, 3'd6, T0};  bf8[7]  = '{3'd5, 3'd7, T2};
        bf8[8]  = '{3'd0, 3'd4, T0};  bf8[9]  = '{3'd1, 3'd5, T1};
        bf8[10] = '{3'd2, 3'd6, T2};  bf8[11] = '{3'd3, 3'd7, T3};
        bf4[0]  = '{3'd0, 3'd1, T0};  bf4[1]  = '{3'd2, 3'd3, T0};
        bf4[2]  = '{3'd0, 3'd2, T0};  bf4[3]  = '{3'd1, 3'd3, T2};
        ld8 = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
        ld4 = '{3'd0, 3'd2, 3'd1, 3'd3};

        use4 = 1'b0;
        rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0; abort = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        cyc; cyc;
        rst_n = 1'b1;
        cyc;
        chk("rst_busy", s_busy, 0);
        chk("rst_in_ready", s_in_ready, 0);
        chk("rst_we", s_we, 0);
        chk("rst_tw", s_tw, 0);
        chk("rst_done", s_done, 0);

        // Reset asserted while in BF_WR
        start8 = 1'b1; cyc; start8 = 1'b0;
        do_load(8, 0, 0);
        cyc;
        chk("pre_rst_we", s_we, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_we", s_we, 0);
        chk("arst_busy", s_busy, 0);
        chk("arst_tw", s_tw, 0);
        chk("arst_wsel", s_wsel, 0);
        chk("arst_waddr", {s_waddr_a, s_waddr_b}, 0);
        chk("arst_raddr", {s_raddr_a, s_raddr_b}, 0);
        cyc;
        rst_n = 1'b1;
        cyc;
        chk("post_rst_busy", s_busy, 0);
        chk("post_rst_in_ready", s_in_ready, 0);

        // Full transform with load gaps and an unload stall at idx 2
        start8 = 1'b1; cyc; start8 = 1'b0;
        do_load(8, 1, 0);
        do_compute(12);
        do_unload(8, 2);

        // Start pulses inside LOAD, then abort during stage1 bf2 write
        start8 = 1'b1; cyc; start8 = 1'b0;
        do_load(8, 1, 1);
        do_compute(6);
        #1;
        chk("ab_rd_raddr_a", s_raddr_a, 4);
        chk("ab_rd_raddr_b", s_raddr_b, 6);
        cyc;
        abort = 1'b1;
        #1;
        chk("ab_we", s_we, 0);
        chk("ab_busy_before", s_busy, 1);
        cyc;
        abort = 1'b0;
        chk("ab_busy", s_busy, 0);
        chk("ab_done", s_done, 0);
        chk("ab_tw", s_tw, 0);
        cyc;
        chk("ab_done_later", s_done, 0);

        start8 = 1'b1; abort = 1'b1;
        cyc;
        start8 = 1'b0; abort = 1'b0;
        chk("start_abort_idle", s_busy, 0);
        cyc;
        chk("start_abort_idle2", s_busy, 0);

        // N=4 instance
        use4 = 1'b1;
        start4 = 1'b1; cyc; start4 = 1'b0;
        do_load(4, 0, 0);
        do_compute(4);
        do_unload(4, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
